debug_hex_viewer: RTL and testbench

- Consumes the core's debug outputs (user registers, stack pointer, instruction fetch address) and drives the six 7-segment displays on the board.
- Replaces a fixed hex_display mapping with a user-steppable viewer.
- Two push-buttons step through 19 debug sources, and a switch enables auto-scroll.
- A second switch freezes a coherent snapshot of all sources.
- Sits beside core_main at top level in the main_clk domain.

---
 rtl/debug_hex_viewer_if.sv | 23 ++
 rtl/debug_hex_viewer.sv | 155 +++++++++++++++
 tb/tb_debug_hex_viewer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_hex_viewer_if.sv
// Debug viewer bus: core debug sources and board controls in, display segments and index out.
interface debug_hex_viewer_if;
  logic [15:0] debug_user_reg [15:0];
  logic [15:0] debug_stack_pointer;
  logic [25:0] debug_instruction_fetch_address;
  logic [1:0]  key_n;
  logic        sw_scroll;
  logic        sw_freeze;
  logic [7:0]  hex_display [5:0];
  logic [4:0]  index_out;

  modport master (
    output debug_user_reg, debug_stack_pointer, debug_instruction_fetch_address,
    output key_n, sw_scroll, sw_freeze,
    input  hex_display, index_out
  );

  modport slave (
    input  debug_user_reg, debug_stack_pointer, debug_instruction_fetch_address,
    input  key_n, sw_scroll, sw_freeze,
    output hex_display, index_out
  );
endinterface

// File: rtl/debug_hex_viewer.sv
// Steppable 7-segment viewer over 19 core debug sources, with auto-scroll and freeze.
module debug_hex_viewer #(
  parameter int unsigned DEBOUNCE_CYCLES = 900000,
  parameter int unsigned SCROLL_CYCLES   = 90000000
) (
  input  logic               main_clk,
  input  logic               reset,
  debug_hex_viewer_if.slave  bus
);

  localparam int unsigned NUM_SRC = 19;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SC_W    = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(SCROLL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SRC - 1);

  logic [1:0]       key_s1, key_s2;
  logic             scroll_s1, scroll_s2, freeze_s1, freeze_s2;
  logic [1:0]       sync_ok;
  logic [DB_W-1:0]  db_cnt  [2];
  logic [DB_W-1:0]  rel_cnt [2];
  logic [1:0]       key_db, armed, pulse;
  logic [SC_W-1:0]  scroll_cnt;
  logic             step_any_c, tick_c;
  logic [IDX_W-1:0] index;
  logic [15:0]      src_c  [NUM_SRC];
  logic [15:0]      snap   [NUM_SRC];
  logic [15:0]      val_c;
  logic [7:0]       hex_q  [5:0];

  // Segment pattern (g..a, active-low) for one hex digit
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Two-flop synchronisers; sync_ok marks when the key synchronisers carry real pin levels
  always_ff @(posedge main_clk) begin
    if (reset) begin
      key_s1    <= 2'b11;
      key_s2    <= 2'b11;
      scroll_s1 <= 1'b0;
      scroll_s2 <= 1'b0;
      freeze_s1 <= 1'b0;
      freeze_s2 <= 1'b0;
      sync_ok   <= 2'b00;
    end else begin
      key_s1    <= bus.key_n;
      key_s2    <= key_s1;
      scroll_s1 <= bus.sw_scroll;
      scroll_s2 <= scroll_s1;
      freeze_s1 <= bus.sw_freeze;
      freeze_s2 <= freeze_s1;
      sync_ok   <= {sync_ok[0], 1'b1};
    end
  end

  // Per-key debounce; a key only steps once it has been seen released long enough after reset
  always_ff @(posedge main_clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        db_cnt[i]  <= '0;
        rel_cnt[i] <= '0;
      end
      key_db <= 2'b11;
      armed  <= 2'b00;
      pulse  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (key_s2[i] != key_db[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            key_db[i] <= key_s2[i];
            db_cnt[i] <= '0;
            pulse[i]  <= armed[i] & ~key_s2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
        if (!armed[i] && sync_ok[1]) begin
          if (!key_s2[i])               rel_cnt[i] <= '0;
          else if (rel_cnt[i] == DB_MAX) armed[i]  <= 1'b1;
          else                          rel_cnt[i] <= rel_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign step_any_c = pulse[0] | pulse[1];
  assign tick_c     = scroll_s2 && !step_any_c && (scroll_cnt == SC_MAX);

  // Auto-scroll period counter; key steps restart it and swallow a coincident tick
  always_ff @(posedge main_clk) begin
    if (reset)                                              scroll_cnt <= '0;
    else if (!scroll_s2 || step_any_c || scroll_cnt == SC_MAX) scroll_cnt <= '0;
    else                                                    scroll_cnt <= scroll_cnt + SC_W'(1);
  end

  // Source index: both keys cancel, then next, prev, scroll tick
  always_ff @(posedge main_clk) begin
    if (reset)                 index <= '0;
    else if (pulse == 2'b11)   index <= index;
    else if (pulse[0] || tick_c) index <= (index == IDX_MAX) ? '0 : index + IDX_W'(1);
    else if (pulse[1])         index <= (index == '0) ? IDX_MAX : index - IDX_W'(1);
  end

  // Live source map
  always_comb begin
    for (int j = 0; j < 16; j++) src_c[j] = bus.debug_user_reg[j];
    src_c[16] = bus.debug_stack_pointer;
    src_c[17] = bus.debug_instruction_fetch_address[15:0];
    src_c[18] = {6'b0, bus.debug_instruction_fetch_address[25:16]};
  end

  // Snapshot follows the sources until freeze is asserted
  always_ff @(posedge main_clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_SRC; j++) snap[j] <= '0;
    end else if (!freeze_s2) begin
      for (int j = 0; j < NUM_SRC; j++) snap[j] <= src_c[j];
    end
  end

  // Selected snapshot value
  always_comb begin
    val_c = '0;
    if (index <= IDX_MAX) val_c = snap[index];
  end

  // Display register: index on HEX5..4 (HEX4 DP = frozen), value on HEX3..0
  always_ff @(posedge main_clk) begin
    if (reset) begin
      for (int d = 0; d < 6; d++) hex_q[d] <= 8'hFF;
    end else begin
      hex_q[0] <= {1'b1, glyph(val_c[3:0])};
      hex_q[1] <= {1'b1, glyph(val_c[7:4])};
      hex_q[2] <= {1'b1, glyph(val_c[11:8])};
      hex_q[3] <= {1'b1, glyph(val_c[15:12])};
      hex_q[4] <= {~freeze_s2, glyph(index[3:0])};
      hex_q[5] <= {1'b1, glyph({3'b000, index[4]})};
    end
  end

  assign bus.hex_display = hex_q;
  assign bus.index_out   = index;

endmodule

// File: tb/tb_debug_hex_viewer.sv
// Scoreboard bench for debug_hex_viewer with a behavioural display model.
module tb_debug_hex_viewer;
  localparam int unsigned DEB = 4;
  localparam int unsigned SCR = 16;
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic main_clk = 1'b0;
  logic reset;
  always #5 main_clk = ~main_clk;

  debug_hex_viewer_if dif();

  debug_hex_viewer #(.DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR)) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .bus      (dif)
  );

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    string            nm;
    logic [4:0]       idx;
    bit               full;
    logic [5:0][7:0]  hex;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int          m_idx;
  logic [15:0] m_reg [16];
  logic [15:0] m_sp;
  logic [25:0] m_fa;
  bit          m_frozen;
  logic [15:0] m_snap [19];

  function automatic logic [15:0] live_src(int k);
    if (k < 16)       return m_reg[k];
    else if (k == 16) return m_sp;
    else if (k == 17) return m_fa[15:0];
    else              return 16'(m_fa >> 16);
  endfunction

  function automatic logic [15:0] shown(int k);
    return m_frozen ? m_snap[k] : live_src(k);
  endfunction

  function automatic logic [5:0][7:0] exp_hex(int k, logic [15:0] v, bit fz);
    logic [5:0][7:0] h;
    h[5] = GLYPH[k / 16];
    h[4] = GLYPH[k % 16] & (fz ? 8'h7F : 8'hFF);
    h[3] = GLYPH[(v / 4096) % 16];
    h[2] = GLYPH[(v / 256) % 16];
    h[1] = GLYPH[(v / 16) % 16];
    h[0] = GLYPH[v % 16];
    return h;
  endfunction

  task automatic push_raw(int due, string nm, int idx, bit full, logic [5:0][7:0] hex);
    exp_t e;
    e.due = due; e.nm = nm; e.idx = 5'(idx); e.full = full; e.hex = hex;
    sb.push_back(e);
  endtask

  task automatic push(int due, string nm, int idx, bit full);
    push_raw(due, nm, idx, full, exp_hex(idx, shown(idx), m_frozen));
  endtask

  // Monitor: compares every due expectation on the falling edge
  exp_t            mon_e;
  logic [5:0][7:0] mon_act;
  always @(negedge main_clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      for (int d = 0; d < 6; d++) mon_act[d] = dif.hex_display[d];
      if (mon_e.due < cyc) begin
        bad++;
        $display("FAIL %s: check due at cycle %0d missed (now %0d)", mon_e.nm, mon_e.due, cyc);
      end else if (dif.index_out !== mon_e.idx || (mon_e.full && mon_act !== mon_e.hex)) begin
        bad++;
        $display("FAIL %s: cycle %0d got index=%0d hex=%h, expected index=%0d hex=%h",
                 mon_e.nm, cyc, dif.index_out, mon_act, mon_e.idx, mon_e.hex);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick(1);
  endtask

  task automatic now_chk(string nm);
    push(cyc, nm, m_idx, 1'b1);
  endtask

  task automatic drive_src();
    for (int i = 0; i < 16; i++) dif.debug_user_reg[i] = m_reg[i];
    dif.debug_stack_pointer             = m_sp;
    dif.debug_instruction_fetch_address = m_fa;
  endtask

  // k=0 next, k=1 prev; full press-and-release
  task automatic press(int k);
    dif.key_n[k] = 1'b0;
    tick(10);
    dif.key_n[k] = 1'b1;
    tick(10);
    m_idx = (k == 0) ? (m_idx + 1) % 19 : (m_idx + 18) % 19;
  endtask

  task automatic goto_idx(int t);
    while (m_idx != t) begin
      if (((t - m_idx + 19) % 19) <= 9) press(0);
      else                              press(1);
    end
  endtask

  logic [5:0][7:0] blank;
  int c0, lat, t_tick, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blank = '1;
    reset = 1'b1;
    dif.key_n = 2'b11; dif.sw_scroll = 1'b0; dif.sw_freeze = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'($urandom);
    m_reg[0] = 16'hA5C3;
    m_sp = 16'($urandom); m_fa = 26'($urandom);
    m_idx = 0; m_frozen = 1'b0;
    drive_src();
    tick(3);

    // 1: blank in reset and up to the first released edge, then reg0 two edges later
    push_raw(cyc, "reset_blank", 0, 1'b1, blank);
    tick(1);
    reset = 1'b0;
    c0 = cyc;
    push_raw(c0, "pre_first_edge_blank", 0, 1'b1, blank);
    push(c0 + 2, "reset_release_A5C3", 0, 1'b1);
    tick(10);

    // 2: long hold gives one step, short glitch none
    c0 = cyc; lat = -1;
    dif.key_n[0] = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (lat < 0 && dif.index_out != 5'd0) lat = cyc - c0;
    end
    tick(1);
    dif.key_n[0] = 1'b1;
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL key_step_seen: no index change within 20 cycles, expected one step");
      lat = 3 + DEB;
    end
    m_idx = 1;
    tick(10);
    now_chk("hold_one_step");
    dif.key_n[0] = 1'b0; tick(2); dif.key_n[0] = 1'b1; tick(15);
    now_chk("glitch_no_step");
    m_fa = 26'h3FF_1234; drive_src();
    press(1); now_chk("prev_to_0");
    press(1); now_chk("prev_wrap_18_03FF");
    press(1); now_chk("prev_17_1234");

    // Randomized stepping with changing sources
    for (int i = 0; i < 12; i++) begin
      m_reg[$urandom_range(0, 15)] = 16'($urandom);
      m_sp = 16'($urandom);
      drive_src();
      press(int'($urandom_range(0, 1)));
      now_chk("rand_step");
    end

    // 3: both keys together leave the index alone
    goto_idx(5);
    dif.key_n = 2'b00; tick(10); dif.key_n = 2'b11; tick(10);
    now_chk("both_keys_idx5");

    // 4: auto-scroll wrap 18 -> 0
    goto_idx(18);
    dif.sw_scroll = 1'b1;
    c0 = cyc;
    push(c0 + SCR, "scroll_not_yet", 18, 1'b0);
    push(c0 + SCR + 4, "scroll_wrap_0", 0, 1'b1);
    m_idx = 0;
    tick(SCR + 4);
    t_tick = -1;
    for (int i = 0; i < 3 * SCR && t_tick < 0; i++) begin
      tick(1);
      if (dif.index_out != 5'(m_idx)) t_tick = cyc;
    end
    total++;
    if (t_tick < 0) begin
      bad++;
      $display("FAIL scroll_period: no scroll advance within %0d cycles, expected one", 3 * SCR);
    end else begin
      m_idx = (m_idx + 1) % 19;
      // next press whose step lands exactly on the following tick
      if (t_tick + SCR - lat >= cyc) wait_until(t_tick + SCR - lat);
      dif.key_n[0] = 1'b0;
      push(t_tick + SCR, "tick_and_key_single", (m_idx + 1) % 19, 1'b0);
      push(t_tick + 2 * SCR - 1, "tick_restart_hold", (m_idx + 1) % 19, 1'b0);
      push(t_tick + 2 * SCR, "tick_restart", (m_idx + 2) % 19, 1'b0);
      tick(10);
      dif.key_n[0] = 1'b1;
      wait_until(t_tick + 2 * SCR + 1);
      m_idx = (m_idx + 2) % 19;
    end
    dif.sw_scroll = 1'b0;
    tick(8);
    now_chk("scroll_off");

    // 5: freeze holds old stack pointer while stepping
    m_sp = 16'h1111; drive_src();
    goto_idx(14);
    tick(4);
    dif.sw_freeze = 1'b1;
    m_frozen = 1'b1;
    for (int k = 0; k < 19; k++) m_snap[k] = live_src(k);
    tick(4);
    m_sp = 16'h2222; drive_src();
    goto_idx(16);
    now_chk("frozen_sp_1111");
    dif.sw_freeze = 1'b0;
    m_frozen = 1'b0;
    push(cyc + 4, "unfreeze_2222", 16, 1'b1);
    tick(6);

    // 6: reset mid-debounce while frozen; held key must be released first
    dif.sw_freeze = 1'b1;
    m_frozen = 1'b1;
    for (int k = 0; k < 19; k++) m_snap[k] = live_src(k);
    tick(4);
    dif.key_n[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    push_raw(cyc, "reset_mid_blank", 0, 1'b1, blank);
    dif.sw_freeze = 1'b0;
    m_frozen = 1'b0;
    m_idx = 0;
    tick(2);
    reset = 1'b0;
    tick(30);
    now_chk("held_after_reset");
    dif.key_n[0] = 1'b1;
    tick(15);
    now_chk("release_after_reset");
    press(0);
    now_chk("repress_after_reset");

    n = 0;
    while (sb.size() > 0 && n < 100) begin tick(1); n++; end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d checks pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
